// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-wide UART transmit engine between NUM_REQ byte producers.
//   An idle arbiter grants the first requester found scanning round-robin from
//   rr_ptr; the winner keeps the engine for up to MAX_BURST bytes, until it
//   flags a last byte, or until it withdraws its request.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   IDX_W     owner/pointer index width, 2**IDX_W >= NUM_REQ
//   MAX_BURST maximum bytes per grant (1..15)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   req       per-requester byte available (level, held until ack)
//   req_data  byte of requester i on [8i+7:8i]
//   req_last  byte of requester i ends its packet
//   ack       one-cycle pulse, byte of that requester consumed
//   busy      a grant is held
//   owner     index of the current/last granted requester
//   tx_data   byte presented to the transmit engine
//   tx_start  one-cycle pulse, engine latches tx_data
//   tx_ready  engine idle and able to accept a byte
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_ready
);

    typedef enum logic [1:0] {
        sIdle  = 2'd0,
        sIssue = 2'd1,
        sWait  = 2'd2,
        sHold  = 2'd3
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [3:0]         r_burst_cnt;
    logic               r_last_seen;

    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_own_req;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic [NUM_REQ-1:0] w_own_onehot;
    logic [IDX_W-1:0]   w_rr_next;
    logic               w_burst_full;

    // Round-robin pick: first set req bit at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    always_comb begin
        logic        found;
        int unsigned k;
        found = 1'b0;
        k     = 0;
        w_sel = '0;
        w_any = |req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(r_rr_ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                w_sel = IDX_W'(k);
            end
        end
    end

    // Signals of the current owner, selected by a loop to keep every index in range.
    always_comb begin
        w_own_req    = 1'b0;
        w_own_last   = 1'b0;
        w_own_data   = '0;
        w_own_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_req       = req[i];
                w_own_last      = req_last[i];
                w_own_data      = req_data[8*i +: 8];
                w_own_onehot[i] = 1'b1;
            end
        end
    end

    assign w_rr_next    = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_burst_full = (r_burst_cnt == 4'(MAX_BURST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= sIdle;
            r_ack       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                sIdle: begin
                    if (w_any) begin
                        r_owner     <= w_sel;
                        r_burst_cnt <= '0;
                        r_state     <= sIssue;
                    end
                end
                sIssue: begin
                    // A withdrawn request wins over tx_ready in the same cycle.
                    if (!w_own_req) begin
                        r_rr_ptr    <= w_rr_next;
                        r_burst_cnt <= '0;
                        r_state     <= sIdle;
                    end else if (tx_ready) begin
                        r_tx_start  <= 1'b1;
                        r_ack       <= w_own_onehot;
                        r_tx_data   <= w_own_data;
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                        r_last_seen <= w_own_last;
                        r_state     <= sHold;
                    end
                end
                // One dead cycle lets the engine drop tx_ready after tx_start.
                sHold: r_state <= sWait;
                sWait: begin
                    if (tx_ready) begin
                        if (r_last_seen || w_burst_full || !w_own_req) begin
                            r_rr_ptr    <= w_rr_next;
                            r_burst_cnt <= '0;
                            r_state     <= sIdle;
                        end else begin
                            r_state <= sIssue;
                        end
                    end
                end
                default: r_state <= sIdle;
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign owner    = r_owner;
    assign busy     = (r_state != sIdle);

endmodule
